// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 48-bit SRAM controller.
// The three access phases of one fixed two-cycle SRAM transfer.
package sram_pkg;

   localparam int CHIPS  = 3;
   localparam int LANE_W = 16;
   localparam int ADDR_W = 20;
   localparam int DATA_W = CHIPS * LANE_W;
   localparam int MASK_W = 2 * CHIPS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2
   } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Word-bus request/response bundle between the block-transfer wrapper and sram_ctrl.
interface sram_ctrl_if;
   import sram_pkg::*;

   logic              wb_stb;
   logic [31:0]       wb_addr;
   logic [MASK_W-1:0] wb_we;
   logic [DATA_W-1:0] wb_din;
   logic [DATA_W-1:0] wb_dout;
   logic              wb_nak;

   modport master (
      output wb_stb, wb_addr, wb_we, wb_din,
      input  wb_dout, wb_nak
   );

   modport slave (
      input  wb_stb, wb_addr, wb_we, wb_din,
      output wb_dout, wb_nak
   );

endinterface

// File: rtl/sram_ctrl_lane.sv
// Per-chip strobe generator: turns the upcoming state and this chip's byte mask
// into registered, active-low SRAM control pins plus a registered data-drive enable.
module sram_lane_ctrl
   import sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  state_t     state_d_i,
   input  logic       isRead_i,
   input  logic [1:0] mask_i,
   output logic       ceN_o,
   output logic       oeN_o,
   output logic       weN_o,
   output logic       ubN_o,
   output logic       lbN_o,
   output logic       drvEn_o
);

   logic ceN_d, oeN_d, weN_d, ubN_d, lbN_d, drvEn_d;
   logic active;

   // Strobes are computed from next state so the pins themselves come straight from flops.
   always_comb begin
      ceN_d   = 1'b1;
      oeN_d   = 1'b1;
      weN_d   = 1'b1;
      ubN_d   = 1'b1;
      lbN_d   = 1'b1;
      drvEn_d = 1'b0;
      active  = (state_d_i != IDLE);
      if (active) begin
         if (isRead_i) begin
            ceN_d = 1'b0;
            oeN_d = 1'b0;
            ubN_d = 1'b0;
            lbN_d = 1'b0;
         end else begin
            drvEn_d = 1'b1;
            if (|mask_i) begin
               ceN_d = 1'b0;
               ubN_d = ~mask_i[1];
               lbN_d = ~mask_i[0];
               weN_d = (state_d_i != ACC1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ceN_o   <= 1'b1;
         oeN_o   <= 1'b1;
         weN_o   <= 1'b1;
         ubN_o   <= 1'b1;
         lbN_o   <= 1'b1;
         drvEn_o <= 1'b0;
      end else begin
         ceN_o   <= ceN_d;
         oeN_o   <= oeN_d;
         weN_o   <= weN_d;
         ubN_o   <= ubN_d;
         lbN_o   <= lbN_d;
         drvEn_o <= drvEn_d;
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// Two-cycle controller bridging the stb/nak word bus to three parallel 1Mx16 async SRAMs.
// One request per three clocks; wb_nak is the only back-pressure.
module sram_ctrl #(
   parameter int ADDR_W = 20,
   parameter int CHIPS  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_ctrl_if.slave           bus,
   output logic [CHIPS-1:0]     sram_ce_n,
   output logic [CHIPS-1:0]     sram_oe_n,
   output logic [CHIPS-1:0]     sram_we_n,
   output logic [CHIPS-1:0]     sram_ub_n,
   output logic [CHIPS-1:0]     sram_lb_n,
   output logic [ADDR_W-1:0]    sram_addr,
   inout  wire  [16*CHIPS-1:0]  sram_data
);
   import sram_pkg::*;

   localparam int DW = LANE_W * CHIPS;

   state_t             state_q, state_d;
   logic [2*CHIPS-1:0] we_q, we_d;
   logic [DW-1:0]      din_q, dout_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               accept, isRead_d;
   logic [CHIPS-1:0]   drvEn;

   // Requests are only taken in IDLE; strobes arriving during an access are dropped.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: if (bus.wb_stb) begin
            accept  = 1'b1;
            state_d = ACC1;
            we_d    = bus.wb_we;
         end
         ACC1:    state_d = ACC2;
         ACC2:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      isRead_d = (we_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= '0;
         din_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q   <= bus.wb_we;
            din_q  <= bus.wb_din;
            addr_q <= bus.wb_addr[ADDR_W+1:2];
         end
         if (state_q == ACC2 && we_q == '0)
            dout_q <= sram_data;
      end
   end

   assign bus.wb_nak  = (state_q != IDLE);
   assign bus.wb_dout = dout_q;
   assign sram_addr   = addr_q;

   // The whole 48-bit bus is driven on any write so every chip sees defined data.
   for (genvar k = 0; k < CHIPS; k++) begin : g_lane
      sram_lane_ctrl u_lane (
         .clk       (clk),
         .rst       (rst),
         .state_d_i (state_d),
         .isRead_i  (isRead_d),
         .mask_i    (we_d[2*k +: 2]),
         .ceN_o     (sram_ce_n[k]),
         .oeN_o     (sram_oe_n[k]),
         .weN_o     (sram_we_n[k]),
         .ubN_o     (sram_ub_n[k]),
         .lbN_o     (sram_lb_n[k]),
         .drvEn_o   (drvEn[k])
      );
      assign sram_data[LANE_W*k +: LANE_W] = drvEn[k] ? din_q[LANE_W*k +: LANE_W] : {LANE_W{1'bz}};
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small read-only SRAM model on the shared data bus.
module tb_sram_ctrl;
   import sram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_ctrl_if bus ();

   logic [2:0]  ce_n, oe_n, we_n, ub_n, lb_n;
   logic [19:0] sram_addr;
   wire  [47:0] sram_data;
   logic [47:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   sram_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_ce_n (ce_n),
      .sram_oe_n (oe_n),
      .sram_we_n (we_n),
      .sram_ub_n (ub_n),
      .sram_lb_n (lb_n),
      .sram_addr (sram_addr),
      .sram_data (sram_data)
   );

   // Model chips drive the bus only while all output enables are low.
   assign sram_data = (oe_n == 3'b000 && we_n == 3'b111) ? mem[sram_addr[3:0]] : 48'bz;

   task automatic test_reset();
      #3 rst = 1'b0;
      #1;
      total++; if (bus.wb_nak !== 1'b0) begin bad++; $display("[TB] FAIL reset_nak: got %b want 0", bus.wb_nak); end
      total++; if (bus.wb_dout !== 48'h0) begin bad++; $display("[TB] FAIL reset_dout: got %h want 0", bus.wb_dout); end
      total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 15'h7FFF) begin bad++; $display("[TB] FAIL reset_strobes: got %b want all ones", {ce_n, oe_n, we_n, ub_n, lb_n}); end
      total++; if (sram_addr !== 20'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0", sram_addr); end
      @(negedge clk);
      rst = 1'b1;
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h10; bus.wb_we = 6'h3F; bus.wb_din = 48'hDEAD_BEEF_CAFE;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (we_n !== 3'b000) begin bad++; $display("[TB] FAIL abort_pre_we: got %b want 000", we_n); end
      #2 rst = 1'b0;
      #1;
      total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 15'h7FFF) begin bad++; $display("[TB] FAIL abort_strobes: got %b want all ones", {ce_n, oe_n, we_n, ub_n, lb_n}); end
      total++; if (bus.wb_nak !== 1'b0) begin bad++; $display("[TB] FAIL abort_nak: got %b want 0", bus.wb_nak); end
      total++; if (sram_data === 48'hDEAD_BEEF_CAFE) begin bad++; $display("[TB] FAIL abort_bus_released: got %h still driven", sram_data); end
      @(negedge clk);
      rst = 1'b1;
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h4; bus.wb_we = 6'h00;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (bus.wb_nak !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_accept: got nak %b want 1", bus.wb_nak); end
      total++; if (sram_addr !== 20'h1) begin bad++; $display("[TB] FAIL post_reset_addr: got %h want 1", sram_addr); end
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.wb_dout !== 48'h1001_2001_3001) begin bad++; $display("[TB] FAIL post_reset_dout: got %h want 100120013001", bus.wb_dout); end
   endtask

   task automatic test_full_write();
      total++; if (bus.wb_nak !== 1'b0) begin bad++; $display("[TB] FAIL fw_nak0: got %b want 0", bus.wb_nak); end
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h10; bus.wb_we = 6'h3F; bus.wb_din = 48'h0123_4567_89AB;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (bus.wb_nak !== 1'b1) begin bad++; $display("[TB] FAIL fw_nak1: got %b want 1", bus.wb_nak); end
      total++; if (sram_addr !== 20'h4) begin bad++; $display("[TB] FAIL fw_addr: got %h want 4", sram_addr); end
      total++; if (we_n !== 3'b000) begin bad++; $display("[TB] FAIL fw_acc1_we: got %b want 000", we_n); end
      total++; if (ce_n !== 3'b000 || oe_n !== 3'b111) begin bad++; $display("[TB] FAIL fw_acc1_ce_oe: got ce %b oe %b want 000/111", ce_n, oe_n); end
      total++; if (sram_data !== 48'h0123_4567_89AB) begin bad++; $display("[TB] FAIL fw_acc1_data: got %h want 0123456789ab", sram_data); end
      @(negedge clk);
      total++; if (bus.wb_nak !== 1'b1) begin bad++; $display("[TB] FAIL fw_nak2: got %b want 1", bus.wb_nak); end
      total++; if (we_n !== 3'b111) begin bad++; $display("[TB] FAIL fw_acc2_we: got %b want 111", we_n); end
      total++; if (sram_data !== 48'h0123_4567_89AB) begin bad++; $display("[TB] FAIL fw_acc2_hold: got %h want 0123456789ab", sram_data); end
      @(negedge clk);
      total++; if (bus.wb_nak !== 1'b0) begin bad++; $display("[TB] FAIL fw_nak3: got %b want 0", bus.wb_nak); end
      total++; if (ce_n !== 3'b111) begin bad++; $display("[TB] FAIL fw_idle_ce: got %b want 111", ce_n); end
      total++; if (sram_data === 48'h0123_4567_89AB) begin bad++; $display("[TB] FAIL fw_idle_release: got %h still driven", sram_data); end
      total++; if (bus.wb_dout !== 48'h1001_2001_3001) begin bad++; $display("[TB] FAIL fw_dout_kept: got %h want 100120013001", bus.wb_dout); end
   endtask

   task automatic test_read();
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h0; bus.wb_we = 6'h00;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (oe_n !== 3'b000 || ce_n !== 3'b000) begin bad++; $display("[TB] FAIL rd_acc1_oe_ce: got oe %b ce %b want 000/000", oe_n, ce_n); end
      total++; if (ub_n !== 3'b000 || lb_n !== 3'b000) begin bad++; $display("[TB] FAIL rd_acc1_bytes: got ub %b lb %b want 000/000", ub_n, lb_n); end
      total++; if (we_n !== 3'b111) begin bad++; $display("[TB] FAIL rd_acc1_we: got %b want 111", we_n); end
      @(negedge clk);
      total++; if (we_n !== 3'b111 || oe_n !== 3'b000) begin bad++; $display("[TB] FAIL rd_acc2: got we %b oe %b want 111/000", we_n, oe_n); end
      @(negedge clk);
      total++; if (bus.wb_dout !== 48'h0000_1234_5678) begin bad++; $display("[TB] FAIL rd_dout: got %h want 000012345678", bus.wb_dout); end
      total++; if (bus.wb_nak !== 1'b0 || oe_n !== 3'b111) begin bad++; $display("[TB] FAIL rd_done: got nak %b oe %b want 0/111", bus.wb_nak, oe_n); end
   endtask

   task automatic test_partial_write();
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h8; bus.wb_we = 6'b000110; bus.wb_din = 48'hAAAA_BBBB_CCCC;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (ce_n !== 3'b100) begin bad++; $display("[TB] FAIL pw_ce: got %b want 100", ce_n); end
      total++; if (lb_n !== 3'b101) begin bad++; $display("[TB] FAIL pw_lb: got %b want 101", lb_n); end
      total++; if (ub_n !== 3'b110) begin bad++; $display("[TB] FAIL pw_ub: got %b want 110", ub_n); end
      total++; if (we_n !== 3'b100) begin bad++; $display("[TB] FAIL pw_we_acc1: got %b want 100", we_n); end
      total++; if (oe_n !== 3'b111) begin bad++; $display("[TB] FAIL pw_oe: got %b want 111", oe_n); end
      @(negedge clk);
      total++; if (we_n !== 3'b111) begin bad++; $display("[TB] FAIL pw_we_acc2: got %b want 111", we_n); end
      @(negedge clk);
      total++; if (bus.wb_dout !== 48'h0000_1234_5678) begin bad++; $display("[TB] FAIL pw_dout_kept: got %h want 000012345678", bus.wb_dout); end
   endtask

   task automatic test_back_to_back();
      logic [47:0] expData;
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h0; bus.wb_we = 6'h00;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         total++; if (bus.wb_nak !== 1'b1 || sram_addr !== 20'(i)) begin bad++; $display("[TB] FAIL b2b_acc1[%0d]: got nak %b addr %h want 1/%h", i, bus.wb_nak, sram_addr, 20'(i)); end
         bus.wb_addr = 32'((i + 1) * 4);
         if (i == 15) bus.wb_stb = 1'b0;
         @(negedge clk);
         total++; if (bus.wb_nak !== 1'b1) begin bad++; $display("[TB] FAIL b2b_acc2[%0d]: got nak %b want 1", i, bus.wb_nak); end
         @(negedge clk);
         expData = (i == 0) ? 48'h0000_1234_5678 : {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i)};
         total++; if (bus.wb_nak !== 1'b0 || bus.wb_dout !== expData) begin bad++; $display("[TB] FAIL b2b_done[%0d]: got nak %b dout %h want 0/%h", i, bus.wb_nak, bus.wb_dout, expData); end
      end
   endtask

   task automatic test_busy_ignore();
      bus.wb_stb = 1'b1; bus.wb_addr = 32'h20; bus.wb_we = 6'h00;
      @(negedge clk);
      bus.wb_addr = 32'h40;
      @(negedge clk);
      bus.wb_stb = 1'b0;
      total++; if (sram_addr !== 20'h8) begin bad++; $display("[TB] FAIL busy_addr_acc2: got %h want 8", sram_addr); end
      @(negedge clk);
      total++; if (bus.wb_nak !== 1'b0 || sram_addr !== 20'h8) begin bad++; $display("[TB] FAIL busy_idle: got nak %b addr %h want 0/8", bus.wb_nak, sram_addr); end
      total++; if (bus.wb_dout !== 48'h1008_2008_3008) begin bad++; $display("[TB] FAIL busy_dout: got %h want 100820083008", bus.wb_dout); end
      @(negedge clk);
      total++; if (bus.wb_nak !== 1'b0 || sram_addr !== 20'h8) begin bad++; $display("[TB] FAIL busy_not_taken: got nak %b addr %h want 0/8", bus.wb_nak, sram_addr); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         mem[i] = {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i)};
      mem[0] = 48'h0000_1234_5678;
      bus.wb_stb  = 1'b0;
      bus.wb_addr = 32'h0;
      bus.wb_we   = 6'h00;
      bus.wb_din  = 48'h0;
      test_reset();
      test_full_write();
      test_read();
      test_partial_write();
      test_back_to_back();
      test_busy_ignore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
